// File: rtl/bram2hs_cast_pkg.sv
// ---------------------------------------------------------------------------
// cast_pkg
//   Shared definitions for the BRAM-to-handshake caster (bram2hs_cast).
//   - bram2hs_state_t : FSM state encoding, also exported on the debug port.
//   - clog2_min1      : $clog2 that never returns 0, for counter widths.
// ---------------------------------------------------------------------------
package cast_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } bram2hs_state_t;

  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/bram2hs_cast.sv
// ---------------------------------------------------------------------------
// bram2hs_cast
//   Reads a frame of ADDR_RANGE words out of an external single-port BRAM
//   (one-cycle read latency) and presents them as beats of OUT_SIZE lanes on
//   a valid/ready stream. The producer owns the BRAM and signals a full frame
//   with in_start; in_done pulses once the whole frame has been delivered.
//
//   Build option: define BRAM2HS_CAST_PAD_ZERO_EN to zero the unfilled lanes
//   of a partial last beat. Without it those lanes keep the previous beat's
//   values.
//
// Ports
//   clk            : clock, all state on the rising edge
//   rst            : asynchronous, active-low reset
//   address0/ce0   : BRAM read port; q0 is valid the cycle after ce0=1
//   q0             : BRAM read data
//   in_start       : producer holds a full frame (sampled only in IDLE)
//   in_ready       : high only in IDLE
//   in_done        : one-cycle pulse after the last beat is accepted
//   data_out       : OUT_SIZE lanes of OUT_WIDTH bits
//   data_out_valid : beat valid (high only in OUT)
//   data_out_ready : downstream accepts the beat
//   state          : debug view of the FSM state
//
// Handshake: a beat transfers on a rising edge where data_out_valid and
// data_out_ready are both 1. Once valid rises, data_out is held stable and
// valid stays high until that transfer; valid never depends on ready, and
// ready is ignored while valid is low.
// ---------------------------------------------------------------------------
module bram2hs_cast
  import cast_pkg::*;
#(
  parameter int OUT_SIZE   = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_RANGE = 100,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] address0,
  output logic                  ce0,
  input  logic [OUT_WIDTH-1:0]  q0,
  input  logic                  in_start,
  output logic                  in_ready,
  output logic                  in_done,
  output logic [OUT_WIDTH-1:0]  data_out [OUT_SIZE],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output bram2hs_state_t        state
);

  // Lane counters must reach OUT_SIZE and the address counter ADDR_RANGE,
  // so both are one value wider than an index.
  localparam int LANE_W = clog2_min1(OUT_SIZE + 1);
  localparam int CNT_W  = clog2_min1(ADDR_RANGE + 1);

  localparam logic [LANE_W-1:0] LANE_FULL = LANE_W'(OUT_SIZE);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(OUT_SIZE - 1);
  localparam logic [CNT_W-1:0]  ADDR_END  = CNT_W'(ADDR_RANGE);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_RANGE - 1);

  bram2hs_state_t       state_q;
  logic [CNT_W-1:0]     addr_cnt;     // next BRAM address to issue
  logic [LANE_W-1:0]    issue_lane;   // lanes issued in the current beat
  logic [LANE_W-1:0]    cap_lane;     // lane the next returning word lands in
  logic                 cap_pend;     // a read was issued last cycle
  logic                 cap_is_last;  // that read was address ADDR_RANGE-1
  logic                 frame_end;    // current beat holds the last word
  logic [OUT_WIDTH-1:0] beat_buf [OUT_SIZE];
  logic                 issue;

  // A read is issued whenever the beat still has free lanes and the frame
  // still has words. When the final capture of a beat happens, one of the
  // two limits has already been reached, so no read overlaps the move to OUT.
  assign issue = (state_q == ST_READ) && (issue_lane < LANE_FULL) &&
                 (addr_cnt < ADDR_END);

  assign ce0            = issue;
  assign address0       = issue ? ADDR_WIDTH'(addr_cnt) : '0;
  assign in_ready       = (state_q == ST_IDLE);
  assign in_done        = (state_q == ST_DONE);
  assign data_out_valid = (state_q == ST_OUT);
  assign state          = state_q;

  always_comb begin
    for (int i = 0; i < OUT_SIZE; i++) begin
      data_out[i] = beat_buf[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_cnt    <= '0;
      issue_lane  <= '0;
      cap_lane    <= '0;
      cap_pend    <= 1'b0;
      cap_is_last <= 1'b0;
      frame_end   <= 1'b0;
      for (int i = 0; i < OUT_SIZE; i++) begin
        beat_buf[i] <= '0;
      end
    end else begin
      // Read-latency pipeline: remember what was issued this cycle so the
      // data returning next cycle can be placed and classified.
      cap_pend    <= issue;
      cap_is_last <= issue && (addr_cnt == ADDR_LAST);

      case (state_q)
        ST_IDLE: begin
          if (in_start) begin
            state_q    <= ST_READ;
            addr_cnt   <= '0;
            issue_lane <= '0;
            cap_lane   <= '0;
            frame_end  <= 1'b0;
`ifdef BRAM2HS_CAST_PAD_ZERO_EN
            for (int i = 0; i < OUT_SIZE; i++) begin
              beat_buf[i] <= '0;
            end
`endif
          end
        end

        ST_READ: begin
          if (issue) begin
            addr_cnt   <= addr_cnt + CNT_W'(1);
            issue_lane <= issue_lane + LANE_W'(1);
          end
          if (cap_pend) begin
            for (int i = 0; i < OUT_SIZE; i++) begin
              if (cap_lane == LANE_W'(i)) begin
                beat_buf[i] <= q0;
              end
            end
            cap_lane <= cap_lane + LANE_W'(1);
            if ((cap_lane == LANE_LAST) || cap_is_last) begin
              state_q   <= ST_OUT;
              frame_end <= cap_is_last;
            end
          end
        end

        ST_OUT: begin
          if (data_out_ready) begin
            if (frame_end) begin
              state_q <= ST_DONE;
            end else begin
              state_q    <= ST_READ;
              issue_lane <= '0;
              cap_lane   <= '0;
`ifdef BRAM2HS_CAST_PAD_ZERO_EN
              // Only lanes that get captured are rewritten, so zeroing here
              // leaves the tail of a partial beat at 0.
              for (int i = 0; i < OUT_SIZE; i++) begin
                beat_buf[i] <= '0;
              end
`endif
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
